// File: rtl/fracn_mmd_ctrl_if.sv
// Control/status bundle between the DSM/PFD side and the frac-N MMD controller.
// master = stimulus/DSM side, slave = the divider controller.
interface fracn_mmd_ctrl_if #(
  parameter int N_W = 8
);
  logic           en;
  logic [N_W-1:0] n_int;
  logic           frac_bit;
  logic           tc;
  logic           div_out;
  logic           mod_sel;
  logic           clamp_err;

  modport master (
    output en, n_int, frac_bit,
    input  tc, div_out, mod_sel, clamp_err
  );

  modport slave (
    input  en, n_int, frac_bit,
    output tc, div_out, mod_sel, clamp_err
  );
endinterface

// File: rtl/fracn_mmd_ctrl.sv
// Multi-modulus divider controller: divides clk by n_int or n_int+1 per period.
// Optional 50% duty feedback clock selected by FRACN_MMD_DUTY50_EN.
module fracn_mmd_ctrl #(
  parameter int N_W   = 8,
  parameter int N_MIN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fracn_mmd_ctrl_if.slave      bus
);

  localparam logic [N_W-1:0] NMinV = N_W'(N_MIN);
  localparam logic [N_W-1:0] OneV  = N_W'(1);

  logic [N_W-1:0] cnt_q, cnt_d;
  logic           tc_q, tc_d;
  logic           mod_sel_q, mod_sel_d;
  logic           clamp_q, clamp_d;

  logic           below_min;
  logic [N_W-1:0] n_eff;
  logic [N_W-1:0] reload;

  // n_eff >= N_MIN >= 1, so n_eff-1+frac_bit never wraps and tops out at 2^N_W-1.
  assign below_min = (bus.n_int < NMinV);
  assign n_eff     = below_min ? NMinV : bus.n_int;
  assign reload    = (n_eff - OneV) + {{(N_W-1){1'b0}}, bus.frac_bit};

`ifdef FRACN_MMD_DUTY50_EN
  logic [N_W-1:0] thresh_q, thresh_d;
  logic [N_W-1:0] half_per;
  logic           div_q, div_d;

  // floor(P/2) without forming the N_W+1 bit period explicitly.
  assign half_per = {1'b0, n_eff[N_W-1:1]} + {{(N_W-1){1'b0}}, n_eff[0] & bus.frac_bit};
`endif

  always_comb begin
    cnt_d     = cnt_q;
    tc_d      = tc_q;
    mod_sel_d = mod_sel_q;
    clamp_d   = clamp_q;
`ifdef FRACN_MMD_DUTY50_EN
    thresh_d  = thresh_q;
    div_d     = div_q;
`endif
    if (!bus.en) begin
      cnt_d = '0;
      tc_d  = 1'b0;
`ifdef FRACN_MMD_DUTY50_EN
      div_d = 1'b0;
`endif
    end else if (cnt_q == '0) begin
      cnt_d     = reload;
      tc_d      = 1'b1;
      mod_sel_d = bus.frac_bit;
      clamp_d   = clamp_q | below_min;
`ifdef FRACN_MMD_DUTY50_EN
      thresh_d  = half_per;
      div_d     = 1'b1;
`endif
    end else begin
      cnt_d = cnt_q - OneV;
      tc_d  = 1'b0;
`ifdef FRACN_MMD_DUTY50_EN
      // High while the remaining count is still in the upper ceil(P/2) slots.
      div_d = (cnt_q - OneV) >= thresh_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      tc_q      <= 1'b0;
      mod_sel_q <= 1'b0;
      clamp_q   <= 1'b0;
`ifdef FRACN_MMD_DUTY50_EN
      thresh_q  <= '0;
      div_q     <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      tc_q      <= tc_d;
      mod_sel_q <= mod_sel_d;
      clamp_q   <= clamp_d;
`ifdef FRACN_MMD_DUTY50_EN
      thresh_q  <= thresh_d;
      div_q     <= div_d;
`endif
    end
  end

  assign bus.tc        = tc_q;
  assign bus.mod_sel   = mod_sel_q;
  assign bus.clamp_err = clamp_q;
`ifdef FRACN_MMD_DUTY50_EN
  assign bus.div_out   = div_q;
`else
  assign bus.div_out   = tc_q;
`endif

endmodule

// File: tb/tb_fracn_mmd_ctrl.sv
// Self-checking bench for fracn_mmd_ctrl: vector table, directed corner sequences
// and a randomized run against a period-position reference model.
module tb_fracn_mmd_ctrl;

  localparam int N_W   = 8;
  localparam int N_MIN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fracn_mmd_ctrl_if #(.N_W(N_W)) bus ();

  fracn_mmd_ctrl #(.N_W(N_W), .N_MIN(N_MIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic [7:0] n;
    logic       f;
    logic       tc;
    logic       md;
    logic       cl;
    logic       d50;
  } vec_t;

  vec_t vecs[14];

  // Reference model: tracks position inside the current period, counting upward.
  bit m_started;
  int m_pos;
  int m_per;
  bit m_tc, m_mod, m_clamp, m_div;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [7:0] n, input logic f);
    bus.en       = e;
    bus.n_int    = n;
    bus.frac_bit = f;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 8'd8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic modelReset();
    m_started = 0;
    m_pos     = 0;
    m_per     = 0;
    m_tc      = 0;
    m_mod     = 0;
    m_clamp   = 0;
    m_div     = 0;
  endtask

  task automatic modelEdge();
    int n;
    n = int'(bus.n_int);
    if (!bus.en) begin
      m_started = 0;
      m_tc      = 0;
    end else if (!m_started || m_pos == m_per - 1) begin
      m_per     = ((n < N_MIN) ? N_MIN : n) + int'(bus.frac_bit);
      m_pos     = 0;
      m_started = 1;
      m_tc      = 1;
      m_mod     = bus.frac_bit;
      if (n < N_MIN) m_clamp = 1;
    end else begin
      m_pos++;
      m_tc = 0;
    end
`ifdef FRACN_MMD_DUTY50_EN
    m_div = m_started && (m_pos < (m_per + 1) / 2);
`else
    m_div = m_tc;
`endif
  endtask

  initial begin
    int acc;
    int carry;
    int tcCount;
    int cyc;
    int lastTc;
    int firstTc;
    int fracUsed;
    logic expDiv;

    applyStimulus(1'b0, 8'd8, 1'b0);

    // Reset state
    doReset();
    checkOutput("rst_tc", bus.tc, 0);
    checkOutput("rst_div", bus.div_out, 0);
    checkOutput("rst_mod", bus.mod_sel, 0);
    checkOutput("rst_clamp", bus.clamp_err, 0);

    // Vector table
    vecs[0]  = '{1'b1, 8'd4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 8'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 8'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'd4,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 8'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 8'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'd2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 8'd10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 8'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].en, vecs[i].n, vecs[i].f);
      tick();
`ifdef FRACN_MMD_DUTY50_EN
      expDiv = vecs[i].d50;
`else
      expDiv = vecs[i].tc;
`endif
      checkOutput($sformatf("vec%0d_tc", i), bus.tc, vecs[i].tc);
      checkOutput($sformatf("vec%0d_mod", i), bus.mod_sel, vecs[i].md);
      checkOutput($sformatf("vec%0d_clamp", i), bus.clamp_err, vecs[i].cl);
      checkOutput($sformatf("vec%0d_div", i), bus.div_out, expDiv);
    end

    // Divide by 8, integer mode
    doReset();
    applyStimulus(1'b1, 8'd8, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      tick();
      checkOutput($sformatf("div8_tc_e%0d", k), bus.tc, (k % 8) == 1);
    end
    checkOutput("div8_mod", bus.mod_sel, 0);

    // Divide by 9 with frac_bit held high
    doReset();
    applyStimulus(1'b1, 8'd8, 1'b1);
    for (int k = 1; k <= 19; k++) begin
      tick();
      checkOutput($sformatf("div9_tc_e%0d", k), bus.tc, (k % 9) == 1);
    end
    checkOutput("div9_mod", bus.mod_sel, 1);

    // Ratio change mid-period takes effect only at the next boundary
    doReset();
    applyStimulus(1'b1, 8'd8, 1'b0);
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 4) applyStimulus(1'b1, 8'd12, 1'b0);
      if (k >= 5) checkOutput($sformatf("nchg_tc_e%0d", k), bus.tc, (k == 9) || (k == 21));
    end

    // Clamp to N_MIN, sticky error flag
    doReset();
    applyStimulus(1'b1, 8'd2, 1'b0);
    for (int k = 1; k <= 23; k++) begin
      tick();
      if (k == 1) checkOutput("clamp_set", bus.clamp_err, 1);
      if (k == 9) applyStimulus(1'b1, 8'd10, 1'b0);
      checkOutput($sformatf("clamp_tc_e%0d", k), bus.tc,
                  (k == 1) || (k == 5) || (k == 9) || (k == 13) || (k == 23));
    end
    checkOutput("clamp_sticky", bus.clamp_err, 1);

    // Async reset mid-period, then enable gating
    doReset();
    applyStimulus(1'b1, 8'd2, 1'b1);
    tick();
    applyStimulus(1'b1, 8'd8, 1'b1);
    for (int k = 2; k <= 9; k++) tick();
    checkOutput("midrst_pre_mod", bus.mod_sel, 1);
    checkOutput("midrst_pre_clamp", bus.clamp_err, 1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_tc", bus.tc, 0);
    checkOutput("midrst_div", bus.div_out, 0);
    checkOutput("midrst_mod", bus.mod_sel, 0);
    checkOutput("midrst_clamp", bus.clamp_err, 0);
    tick();
    checkOutput("midrst_hold_tc", bus.tc, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 8'd8, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick();
      checkOutput($sformatf("en0_tc_%0d", k), bus.tc, 0);
      checkOutput($sformatf("en0_div_%0d", k), bus.div_out, 0);
    end
    applyStimulus(1'b1, 8'd8, 1'b0);
    tick();
    checkOutput("en1_tc", bus.tc, 1);

    // First-order DSM at mid-scale: periods alternate 8/9
    doReset();
    acc = 128;
    tcCount = 0;
    cyc = 0;
    lastTc = 0;
    firstTc = 0;
    fracUsed = 0;
    applyStimulus(1'b1, 8'd8, 1'b0);
    while (tcCount < 65 && cyc < 1000) begin
      tick();
      cyc++;
      if (bus.tc) begin
        tcCount++;
        if (tcCount == 1) firstTc = cyc;
        else checkOutput($sformatf("dsm_per%0d", tcCount - 1), cyc - lastTc, 8 + fracUsed);
        lastTc = cyc;
        fracUsed = int'(bus.frac_bit);
        acc = acc + 128;
        carry = acc / 256;
        acc = acc % 256;
        bus.frac_bit = carry[0];
      end
    end
    checkOutput("dsm_tc_count", tcCount, 65);
    checkOutput("dsm_span", lastTc - firstTc, 544);

`ifdef FRACN_MMD_DUTY50_EN
    // 50% duty: P=9 -> 5 high, 4 low
    doReset();
    applyStimulus(1'b1, 8'd9, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      tick();
      checkOutput($sformatf("duty_div_e%0d", k), bus.div_out, ((k - 1) % 9) < 5);
    end
`endif

    // Randomized run against the reference model
    doReset();
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput($sformatf("rnd_rst_tc_c%0d", c), bus.tc, m_tc);
        checkOutput($sformatf("rnd_rst_clamp_c%0d", c), bus.clamp_err, m_clamp);
        tick();
        rst = 1'b0;
      end else begin
        applyStimulus($urandom_range(0, 15) != 0,
                      ($urandom_range(0, 99) == 0) ? 8'd255 :
                      ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 5)) :
                                                    8'($urandom_range(4, 14)),
                      1'($urandom_range(0, 1)));
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput($sformatf("rnd_tc_c%0d", c), bus.tc, m_tc);
        checkOutput($sformatf("rnd_div_c%0d", c), bus.div_out, m_div);
        checkOutput($sformatf("rnd_mod_c%0d", c), bus.mod_sel, m_mod);
        checkOutput($sformatf("rnd_clamp_c%0d", c), bus.clamp_err, m_clamp);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
